// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared constants and types for the instruction fetch sequencer.
//   - PC_W / IR_W default widths
//   - state encoding (IDLE/FETCH/EXEC) and the state enum built from it
//   - decode_addr field positions and a helper that packs them
package fetch_sequencer_pkg;

  localparam int unsigned PC_W = 12;
  localparam int unsigned IR_W = 8;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_FETCH = 2'd1;
  localparam logic [1:0] STATE_EXEC  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = STATE_IDLE,
    StFetch = STATE_FETCH,
    StExec  = STATE_EXEC
  } state_t;

  // decode_addr = {opcode[6:3], C[2], Z[1], phase[0]}
  localparam int unsigned DEC_W     = 7;
  localparam int unsigned DA_OP_HI  = 6;
  localparam int unsigned DA_OP_LO  = 3;
  localparam int unsigned DA_C      = 2;
  localparam int unsigned DA_Z      = 1;
  localparam int unsigned DA_PHASE  = 0;

  function automatic logic [DEC_W-1:0] pack_decode(input logic [3:0] opcode, input logic c,
                                                   input logic z, input logic ph);
    logic [DEC_W-1:0] d;
    d = '0;
    d[DA_OP_HI:DA_OP_LO] = opcode;
    d[DA_C]              = c;
    d[DA_Z]              = z;
    d[DA_PHASE]          = ph;
    return d;
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_register.sv
// fetch_sequencer_pc_register: program counter with load (priority) and increment.
// Increment wraps modulo 2^W with no carry out.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (clears to 0)
//   load        - load load_val this cycle (wins over inc)
//   inc         - step by one
//   load_val    - jump target
//   pc          - current program counter
module fetch_sequencer_pc_register #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc
);

  logic [W-1:0] pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else if (load) begin
      pc_q <= load_val;
    end else if (inc) begin
      pc_q <= pc_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch and phase sequencer for the 4-bit microprocessor.
// Owns PC, IR and the {C,Z} flag register; drives the program ROM and forms the
// control-decode address {opcode, C, Z, phase}.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   en            - run enable, sampled only at instruction boundaries
//   rom_addr      - ROM address (= PC)
//   rom_req       - ROM read request (high in FETCH and EXEC)
//   rom_data      - ROM read data
//   rom_valid     - rom_data valid for rom_addr
//   inc_pc        - decode strobe: step PC past the second byte
//   load_pc       - decode strobe: jump to {IR[3:0], second byte}
//   load_flags    - decode strobe: capture flags_in
//   flags_in      - {C,Z} from the ALU
//   decode_addr   - {IR[7:4], C, Z, phase}
//   operand       - IR[3:0]
//   program_byte  - second instruction byte, captured at commit
//   phase         - 0 = fetch, 1 = execute
//   exec_strobe   - one-cycle pulse following each execute commit
// PC_W must equal 4 + IR_W so that a jump target fills the whole PC.
module fetch_sequencer #(
  parameter int unsigned PC_W = 12,
  parameter int unsigned IR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic [PC_W-1:0] rom_addr,
  output logic            rom_req,
  input  logic [IR_W-1:0] rom_data,
  input  logic            rom_valid,
  input  logic            inc_pc,
  input  logic            load_pc,
  input  logic            load_flags,
  input  logic [1:0]      flags_in,
  output logic [6:0]      decode_addr,
  output logic [3:0]      operand,
  output logic [IR_W-1:0] program_byte,
  output logic            phase,
  output logic            exec_strobe
);
  import fetch_sequencer_pkg::*;

  state_t          state_q;
  logic [IR_W-1:0] ir_q;
  logic [1:0]      flags_q;
  logic [IR_W-1:0] pb_q;
  logic            phase_q;
  logic            strobe_q;

  logic            fetch_done;
  logic            commit;
  logic            pc_load;
  logic            pc_inc;
  logic [PC_W-1:0] pc;

  assign fetch_done = (state_q == StFetch) && rom_valid;
  assign commit     = (state_q == StExec) && rom_valid;

  // Fetch always steps to the second byte; decode strobes only matter on commit.
  assign pc_load = commit && load_pc;
  assign pc_inc  = fetch_done || (commit && !load_pc && inc_pc);

  fetch_sequencer_pc_register #(
    .W (PC_W)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val ({ir_q[3:0], rom_data}),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      flags_q  <= '0;
      pb_q     <= '0;
      phase_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (en) state_q <= StFetch;
        end
        StFetch: begin
          if (rom_valid) begin
            ir_q    <= rom_data;
            phase_q <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (rom_valid) begin
            if (load_flags) flags_q <= flags_in;
            pb_q     <= rom_data;
            strobe_q <= 1'b1;
            phase_q  <= 1'b0;
            state_q  <= en ? StFetch : StIdle;
          end
        end
        default: begin
          phase_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rom_addr     = pc;
  assign rom_req      = (state_q != StIdle);
  assign decode_addr  = pack_decode(ir_q[7:4], flags_q[1], flags_q[0], phase_q);
  assign operand      = ir_q[3:0];
  assign program_byte = pb_q;
  assign phase        = phase_q;
  assign exec_strobe  = strobe_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: an instruction-level reference model issues each
// instruction open-loop (chosen ROM wait counts and decode strobes), pushes the
// expected per-cycle outputs into a queue, and an independent monitor compares.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [11:0] rom_addr;
  logic        rom_req;
  logic [7:0]  rom_data;
  logic        rom_valid;
  logic        inc_pc;
  logic        load_pc;
  logic        load_flags;
  logic [1:0]  flags_in;
  logic [6:0]  decode_addr;
  logic [3:0]  operand;
  logic [7:0]  program_byte;
  logic        phase;
  logic        exec_strobe;

  logic [7:0]  rom_mem [4096];
  logic [7:0]  junk;

  fetch_sequencer u_dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .rom_addr     (rom_addr),
    .rom_req      (rom_req),
    .rom_data     (rom_data),
    .rom_valid    (rom_valid),
    .inc_pc       (inc_pc),
    .load_pc      (load_pc),
    .load_flags   (load_flags),
    .flags_in     (flags_in),
    .decode_addr  (decode_addr),
    .operand      (operand),
    .program_byte (program_byte),
    .phase        (phase),
    .exec_strobe  (exec_strobe)
  );

  assign rom_data = rom_valid ? rom_mem[rom_addr] : junk;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state (instruction level)
  logic [11:0] pc_m;
  logic [7:0]  ir_m;
  logic [7:0]  pb_m;
  logic [1:0]  fl_m;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic        req;
    logic        ph;
    logic        stb;
    logic [6:0]  daddr;
    logic [3:0]  opnd;
    logic [7:0]  pbyte;
  } exp_t;

  exp_t q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endfunction

  function automatic void check_all(exp_t e, string tag);
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(e.addr));
    chk({tag, ".rom_req"}, 32'(rom_req), 32'(e.req));
    chk({tag, ".phase"}, 32'(phase), 32'(e.ph));
    chk({tag, ".exec_strobe"}, 32'(exec_strobe), 32'(e.stb));
    chk({tag, ".decode_addr"}, 32'(decode_addr), 32'(e.daddr));
    chk({tag, ".operand"}, 32'(operand), 32'(e.opnd));
    chk({tag, ".program_byte"}, 32'(program_byte), 32'(e.pbyte));
  endfunction

  function automatic exp_t mk(logic ph, logic req, logic stb);
    exp_t e;
    e.cyc   = cyc + 1;
    e.addr  = pc_m;
    e.req   = req;
    e.ph    = ph;
    e.stb   = stb;
    e.daddr = {ir_m[7:4], fl_m, ph};
    e.opnd  = ir_m[3:0];
    e.pbyte = pb_m;
    return e;
  endfunction

  function automatic void push(logic ph, logic req, logic stb);
    q.push_back(mk(ph, req, stb));
  endfunction

  function automatic void model_reset();
    pc_m = '0;
    ir_m = '0;
    pb_m = '0;
    fl_m = '0;
  endfunction

  // Monitor: compares whatever expectation is due this cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        exp_t s;
        s = q.pop_front();
        chk("stale_expectation", 32'(s.cyc), 32'(cyc));
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        check_all(e, "cycle");
      end else if (exec_strobe) begin
        chk("unexpected_exec_strobe", 32'(exec_strobe), 32'd0);
      end
    end
  end

  // Randomise inputs the DUT should ignore this cycle.
  task automatic noise();
    en         = 1'($urandom);
    load_pc    = 1'($urandom);
    inc_pc     = 1'($urandom);
    load_flags = 1'($urandom);
    flags_in   = 2'($urandom);
    junk       = 8'($urandom);
  endtask

  task automatic start();
    @(negedge clk);
    noise();
    en        = 1'b1;
    rom_valid = 1'($urandom);
    push(1'b0, 1'b1, 1'b0);
  endtask

  // One instruction from FETCH: wf/we ROM wait cycles, commit strobes, stop = en low at commit.
  task automatic run_instr(input int wf, input int we, input bit lp, input bit ip, input bit lf,
                           input logic [1:0] fin, input bit stop);
    logic [7:0] byte2;
    for (int i = 0; i <= wf; i++) begin
      @(negedge clk);
      noise();
      rom_valid = (i == wf);
      if (i == wf) begin
        ir_m = rom_mem[pc_m];
        pc_m = pc_m + 12'd1;
        push(1'b1, 1'b1, 1'b0);
      end else begin
        push(1'b0, 1'b1, 1'b0);
      end
    end
    for (int j = 0; j <= we; j++) begin
      @(negedge clk);
      noise();
      rom_valid = (j == we);
      if (j == we) begin
        load_pc    = lp;
        inc_pc     = ip;
        load_flags = lf;
        flags_in   = fin;
        en         = !stop;
        byte2 = rom_mem[pc_m];
        if (lp) pc_m = {ir_m[3:0], byte2};
        else if (ip) pc_m = pc_m + 12'd1;
        if (lf) fl_m = fin;
        pb_m = byte2;
        push(1'b0, !stop, 1'b1);
      end else begin
        push(1'b1, 1'b1, 1'b0);
      end
    end
    if (stop) begin
      @(negedge clk);
      noise();
      en        = 1'b1;
      rom_valid = 1'($urandom);
      push(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom_mem[a] = 8'($urandom);
    rom_mem[12'h000] = 8'h5A;
    rom_mem[12'h002] = 8'h70;
    rom_mem[12'h003] = 8'h10;
    rom_mem[12'h010] = 8'h73;
    rom_mem[12'h011] = 8'h4C;
    rom_mem[12'h34C] = 8'h8F;
    rom_mem[12'h34D] = 8'hFF;

    reset = 1'b1;
    en = 1'b0; rom_valid = 1'b0; inc_pc = 1'b0; load_pc = 1'b0;
    load_flags = 1'b0; flags_in = 2'b00; junk = 8'h00;
    model_reset();
    #1;
    check_all(mk(1'b0, 1'b0, 1'b0), "reset");
    repeat (2) begin
      @(negedge clk);
      push(1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    push(1'b0, 1'b0, 1'b0);
    start();

    // Directed: first instruction, jumps, wait states, wrap, flags, idle on en=0.
    run_instr(0, 0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0); // IR=5A, PC=002, flags=10
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0); // jump to 010, flags kept
    run_instr(3, 2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0); // 7 cycles, jump to 34C
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0); // jump to FFF
    run_instr(0, 1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1); // FFF wraps, EXEC reads 000, then IDLE

    run_random(200);

    // Asynchronous reset while EXEC waits on the ROM.
    @(negedge clk);
    noise();
    en        = 1'b1;
    rom_valid = 1'b1;
    ir_m = rom_mem[pc_m];
    pc_m = pc_m + 12'd1;
    push(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    noise();
    rom_valid = 1'b0;
    push(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rom_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(mk(1'b0, 1'b0, 1'b0), "async_reset");
    en = 1'b0;
    push(1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      push(1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      noise();
      en = 1'b0;
      push(1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    noise();
    en = 1'b0;
    push(1'b0, 1'b0, 1'b0);
    start();
    run_random(40);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
